// File: rtl/busy_gnt_responder.sv
// Handshake responder: per accepted req, NUM_BUSY isolated busy pulses separated
// by programmable gaps, a programmable delay, then one gnt pulse.
module busy_gnt_responder #(
  parameter int CNT_W    = 8,
  parameter int NUM_BUSY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [CNT_W-1:0] busy_gap,
  input  logic [CNT_W-1:0] gnt_delay,
  output logic             busy,
  output logic             gnt,
  output logic             active,
  output logic             req_drop
);

  localparam int PW = $clog2(NUM_BUSY + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GAP  = 3'd1;
  localparam logic [2:0] S_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_GNT  = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] g_q, d_q, gap_q, dly_q;
  logic [CNT_W-1:0] g_nxt, d_nxt, gap_nxt, dly_nxt;
  logic [PW-1:0]    pcnt_q, pcnt_nxt, pcnt_inc;

  assign pcnt_inc = pcnt_q + 1'b1;

  always_comb begin
    state_nxt = state;
    g_nxt     = g_q;
    d_nxt     = d_q;
    gap_nxt   = gap_q;
    dly_nxt   = dly_q;
    pcnt_nxt  = pcnt_q;
    case (state)
      S_IDLE: begin
        if (req) begin
          // A zero gap would allow back-to-back busy; clamp so pulses stay isolated.
          g_nxt     = (busy_gap == '0) ? CNT_W'(1) : busy_gap;
          d_nxt     = gnt_delay;
          gap_nxt   = g_nxt;
          pcnt_nxt  = '0;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q <= CNT_W'(1)) begin
          gap_nxt   = '0;
          state_nxt = S_BUSY;
        end else begin
          gap_nxt = gap_q - 1'b1;
        end
      end
      S_BUSY: begin
        pcnt_nxt = pcnt_inc;
        if (pcnt_inc < PW'(NUM_BUSY)) begin
          gap_nxt   = g_q;
          state_nxt = S_GAP;
        end else if (d_q == '0) begin
          state_nxt = S_GNT;
        end else begin
          dly_nxt   = d_q;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dly_q <= CNT_W'(1)) begin
          dly_nxt   = '0;
          state_nxt = S_GNT;
        end else begin
          dly_nxt = dly_q - 1'b1;
        end
      end
      S_GNT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode the next state so they are registered yet aligned with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      g_q      <= '0;
      d_q      <= '0;
      gap_q    <= '0;
      dly_q    <= '0;
      pcnt_q   <= '0;
      busy     <= 1'b0;
      gnt      <= 1'b0;
      active   <= 1'b0;
      req_drop <= 1'b0;
    end else begin
      state    <= state_nxt;
      g_q      <= g_nxt;
      d_q      <= d_nxt;
      gap_q    <= gap_nxt;
      dly_q    <= dly_nxt;
      pcnt_q   <= pcnt_nxt;
      busy     <= (state_nxt == S_BUSY);
      gnt      <= (state_nxt == S_GNT);
      active   <= (state_nxt != S_IDLE);
      req_drop <= req && (state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_busy_gnt_responder.sv
// Bench for busy_gnt_responder: directed scenarios then random traffic, all
// compared against a cycle-arithmetic model of the pulse schedule.
module tb_busy_gnt_responder;

  localparam int CNT_W = 8;
  localparam int N     = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req = 1'b0;
  logic [CNT_W-1:0] busy_gap = '0;
  logic [CNT_W-1:0] gnt_delay = '0;
  logic             busy, gnt, active, req_drop;

  int checks = 0;
  int errors = 0;

  // Model: one transaction accepted at cycle t0 with gap g and delay d.
  int  cyc = 0;
  bit  have = 0;
  int  t0 = 0, g = 1, d = 0;
  bit  drop_q = 0;

  busy_gnt_responder #(.CNT_W(CNT_W), .NUM_BUSY(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .busy_gap(busy_gap),
    .gnt_delay(gnt_delay), .busy(busy), .gnt(gnt), .active(active),
    .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  function automatic int t_gnt();
    return t0 + N * (g + 1) + d + 1;
  endfunction

  function automatic logic m_busy(int c);
    int k;
    if (!have || c <= t0) return 1'b0;
    k = c - t0;
    return ((k % (g + 1)) == 0) && ((k / (g + 1)) <= N);
  endfunction

  function automatic logic m_gnt(int c);
    return have && (c == t_gnt());
  endfunction

  function automatic logic m_active(int c);
    return have && (c > t0) && (c <= t_gnt());
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: check outputs for cycle cyc, then drive inputs sampled at its end.
  task automatic step(input logic r, input int bg, input int gd);
    @(negedge clk);
    chk("busy", busy, m_busy(cyc));
    chk("gnt", gnt, m_gnt(cyc));
    chk("active", active, m_active(cyc));
    chk("req_drop", req_drop, drop_q);
    req       = r;
    busy_gap  = CNT_W'(bg);
    gnt_delay = CNT_W'(gd);
    drop_q    = r && m_active(cyc);
    if (r && !m_active(cyc)) begin
      have = 1;
      t0   = cyc;
      g    = (bg == 0) ? 1 : bg;
      d    = gd;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, busy_gap, gnt_delay);
  endtask

  // Assert reset away from the clock edge, check outputs clear at once.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", gnt, 1'b0);
    chk("rst_active", active, 1'b0);
    chk("rst_req_drop", req_drop, 1'b0);
    req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    have   = 0;
    drop_q = 0;
  endtask

  initial begin
    // Reset state
    #3;
    chk("por_busy", busy, 1'b0);
    chk("por_gnt", gnt, 1'b0);
    chk("por_active", active, 1'b0);
    chk("por_req_drop", req_drop, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // Gap 1, no delay
    step(1'b1, 1, 0); idle(10);
    // Gap 0 clamps to 1
    step(1'b1, 0, 0); idle(10);
    // Gap 3, delay 5; config change mid-transaction ignored
    step(1'b1, 3, 5); idle(1); step(1'b0, 7, 5); idle(20);
    // Dropped requests at +3 and +7 (the gnt cycle)
    step(1'b1, 1, 0); idle(2); step(1'b1, 1, 0); idle(3); step(1'b1, 1, 0); idle(6);
    // Reset mid-transaction aborts, then a fresh transaction
    step(1'b1, 3, 5); idle(4); mid_reset(); idle(3);
    step(1'b1, 3, 5); idle(25);
    // Maximum counter values
    step(1'b1, 255, 255); idle(1030);

    // Random traffic with random config churn
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 9) < 3), $urandom_range(0, 5), $urandom_range(0, 6));
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/busy_gnt_responder.md
# busy_gnt_responder

Protocol responder that drives the `req`/`busy`/`gnt` handshake consumed by the non-consecutive-busy assertion checker. On each accepted request it emits exactly `NUM_BUSY` isolated single-cycle `busy` pulses with programmable low gaps, waits a programmable delay, then issues one `gnt` pulse. It is the stimulus/slave stage directly upstream of the checker and replaces bench-task stimulus with synthesizable, repeatable timing.

## Interface
Parameters:
- `CNT_W`, default 8: width of the gap and delay counters and their config inputs.
- `NUM_BUSY`, default 3: number of `busy` pulses per transaction; legal range ≥1.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: request; sampled every rising edge, accepted only in IDLE.
- `busy_gap` in CNT_W: low cycles before each busy pulse; 0 is treated as 1.
- `gnt_delay` in CNT_W: low cycles between the last busy pulse and `gnt`; 0 is legal.
- `busy` out 1: busy pulse, registered.
- `gnt` out 1: grant pulse, registered.
- `active` out 1: transaction in progress, registered.
- `req_drop` out 1: one-cycle pulse flagging a `req` that was sampled while not IDLE and ignored.

## Operation
- States: IDLE, GAP, BUSY, WAIT, GNT.
- Reset (async assert) forces IDLE and all counters to 0. Outputs `busy`, `gnt`, `active` and `req_drop` are all 0 during and immediately after reset.
- Reset deassertion does not start a transaction. A reset asserted mid-transaction aborts it with no `gnt`.
- **IDLE:**
  - With `req`=1: latch `g = max(busy_gap,1)` and `d = gnt_delay`, clear the pulse count, load the gap counter with `g`, and go to GAP.
  - Otherwise stay in IDLE.
- **GAP:** decrement the gap counter each cycle. When it reaches 0, go to BUSY.
- **BUSY:** lasts exactly 1 cycle and increments the pulse count.
  - If count < `NUM_BUSY`: reload the gap counter with `g` and go to GAP.
  - Else, if `d`=0: go to GNT.
  - Else: load the delay counter with `d` and go to WAIT.
- **WAIT:** decrement the delay counter each cycle. At 0, go to GNT.
- **GNT:** lasts exactly 1 cycle, then go to IDLE.
- Output decode:
  - `busy` = (state == BUSY).
  - `gnt` = (state == GNT).
  - `active` = (state ≠ IDLE).
- `req`=1 sampled in any non-IDLE state, including GNT:
  - the request is dropped;
  - `req_drop` pulses on the following cycle;
  - the transaction is unaffected.
- Changes to `busy_gap` or `gnt_delay` mid-transaction have no effect. They are used only at the next accept.
- Arithmetic:
  - Counters are `CNT_W` bits, with no wrap: they load at most 2^CNT_W−1 and stop at 0.
  - The pulse count is `$clog2(NUM_BUSY+1)` bits.

## Timing
- Cycle numbering: let `t` be the cycle in which `req` is high while in IDLE.
- `busy` pulse k (k = 1..N, N = `NUM_BUSY`) is high in cycle `t + k·(g+1)`.
- `busy` is never high in two consecutive cycles, because g ≥ 1.
- `busy` is low in cycle `t+1`.
- `gnt` is high in cycle `t + N·(g+1) + d + 1`.
- `active` is high from cycle `t+1` through the `gnt` cycle inclusive.
- The earliest next accepted `req` is in the cycle after `gnt`.
- `busy` and `gnt` are never high in the same cycle.
- `req_drop` goes high in cycle `s+1` when `req` is sampled in non-IDLE cycle `s`.

## Test plan
1. `NUM_BUSY`=3, `busy_gap`=1, `gnt_delay`=0, `req` pulse at cycle 0 -> `busy` at cycles 2, 4, 6; `gnt` at 7; `active` 1–7; checker passes.
2. `busy_gap`=0, `gnt_delay`=0 -> waveform identical to scenario 1 (gap clamped to 1).
3. `busy_gap`=3, `gnt_delay`=5, req at 0; set `busy_gap`=7 at cycle 2 -> `busy` at 4, 8, 12; `gnt` at 18; the mid-run config change is ignored.
4. Scenario 1 with an extra `req` at cycle 3 and at cycle 7 -> `req_drop` at 4 and 8; `busy`/`gnt` timing unchanged; no second transaction.
5. Scenario 3 with `rst_n` low from cycle 5.5 to 7 -> all outputs 0 immediately; no `gnt`. Then `req` at cycle 10 -> `busy` at 14, 18, 22; `gnt` at 28.
6. `CNT_W`=8, `busy_gap`=255, `gnt_delay`=255 -> `busy` at 256, 512, 768; `gnt` at 1024; `active` deasserts at 1025.
